// File: rtl/irq_controller_if.sv
// CPU bus view of the interrupt controller.
// The CPU drives the select, direction, address and write data; the peripheral returns read data.
interface irq_controller_if;
  logic       cs;
  logic       rw;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (
    output cs, rw, addr, data_in,
    input  data_out
  );

  modport slave (
    input  cs, rw, addr, data_in,
    output data_out
  );
endinterface

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller.
// Synchronises the sources, latches them as pending, masks them, and drives irqb to the CPU.
module irq_controller #(
  parameter int          NUM_SRC      = 8,
  parameter logic [7:0]  EDGE_DEFAULT = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  irq_controller_if.slave    bus,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irqb
);

  localparam logic [8:0] ONE_HOT = 9'd1 << NUM_SRC;
  localparam logic [7:0] IMPL    = 8'(ONE_HOT - 9'd1);

  logic [7:0] r_s1, r_s2, r_s3;
  logic [7:0] r_pend, r_mask, r_edge;

  logic [7:0] w_src;
  logic       w_wr;
  logic [7:0] w_wdata;
  logic [7:0] w_ack;
  logic [7:0] w_sw;
  logic [7:0] w_set;
  logic [7:0] w_pm;
  logic [2:0] w_idx;
  logic       w_vld;

  // Widen to 8 bits so unimplemented sources are constant zero.
  always_comb begin
    w_src = '0;
    w_src[NUM_SRC-1:0] = irq_src;
  end

  assign w_wr    = bus.cs & ~bus.rw;
  assign w_wdata = bus.data_in & IMPL;
  assign w_ack   = (w_wr && bus.addr == 3'd2) ? w_wdata : 8'h00;
  assign w_sw    = (w_wr && bus.addr == 3'd5) ? w_wdata : 8'h00;

  assign w_set = ((r_edge & r_s2 & ~r_s3) | (~r_edge & r_s2) | w_sw)
               & IMPL;
  assign w_pm  = r_pend & r_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= w_src;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // A set on the same edge as an ACK takes priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_mask <= '0;
      r_edge <= EDGE_DEFAULT & IMPL;
      irqb   <= 1'b1;
    end else begin
      r_pend <= (r_pend & ~w_ack) | w_set;
      irqb   <= ~|w_pm;
      if (w_wr && bus.addr == 3'd1)
        r_mask <= w_wdata;
      if (w_wr && bus.addr == 3'd4)
        r_edge <= w_wdata;
    end
  end

  always_comb begin
    w_idx = 3'd0;
    w_vld = |w_pm;
    for (int i = 7; i >= 0; i--)
      if (w_pm[i]) w_idx = 3'(i);
  end

  always_comb begin
    bus.data_out = 8'h00;
    case (bus.addr)
      3'd0:    bus.data_out = r_pend;
      3'd1:    bus.data_out = r_mask;
      3'd3:    bus.data_out = w_vld ? {1'b1, 4'b0000, w_idx}
                                    : 8'h00;
      3'd4:    bus.data_out = r_edge;
      3'd6:    bus.data_out = r_s2;
      default: bus.data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller.
// Each task drives one scenario and compares against hand-computed values.
module tb_irq_controller;

  logic       clk;
  logic       rst;
  logic [7:0] irq_src;
  logic       irqb;

  int errors;
  int checks;

  irq_controller_if bus ();

  irq_controller #(
    .NUM_SRC      (8),
    .EDGE_DEFAULT (8'hFF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .irq_src (irq_src),
    .irqb    (irqb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cs      = 1'b1;
    bus.rw      = 1'b0;
    bus.addr    = a;
    bus.data_in = d;
    @(negedge clk);
    bus.cs      = 1'b0;
    bus.rw      = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    bus.cs   = 1'b1;
    bus.rw   = 1'b1;
    bus.addr = a;
    #1;
    d = bus.data_out;
    bus.cs = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    @(negedge clk);
    irq_src = v;
    @(negedge clk);
    irq_src = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (irqb !== 1'b1) begin
      errors++;
      $display("FAIL reset_irqb got %b exp 1", irqb);
    end
    rd(3'd0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL reset_status got %h exp 00", d);
    end
    rd(3'd1, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL reset_mask got %h exp 00", d);
    end
    rd(3'd4, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++;
      $display("FAIL reset_edge got %h exp FF", d);
    end
    rd(3'd3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL reset_active got %h exp 00", d);
    end
  endtask

  task automatic test_edge_latency();
    logic [7:0] d;
    wr(3'd1, 8'h01);
    pulse(8'h01);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (irqb !== 1'b1) begin
      errors++;
      $display("FAIL lat_early_irqb got %b exp 1", irqb);
    end
    @(negedge clk);
    checks++;
    if (irqb !== 1'b0) begin
      errors++;
      $display("FAIL lat_irqb got %b exp 0", irqb);
    end
    rd(3'd0, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL lat_status got %h exp 01", d);
    end
    rd(3'd3, d);
    checks++;
    if (d !== 8'h80) begin
      errors++;
      $display("FAIL lat_active got %h exp 80", d);
    end
    wr(3'd2, 8'h01);
    rd(3'd0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL ack_status got %h exp 00", d);
    end
    @(negedge clk);
    checks++;
    if (irqb !== 1'b1) begin
      errors++;
      $display("FAIL ack_irqb got %b exp 1", irqb);
    end
  endtask

  task automatic test_level();
    logic [7:0] d;
    wr(3'd4, 8'hFD);
    wr(3'd1, 8'h02);
    @(negedge clk);
    irq_src = 8'h02;
    repeat (4) @(negedge clk);
    rd(3'd6, d);
    checks++;
    if (d !== 8'h02) begin
      errors++;
      $display("FAIL level_raw got %h exp 02", d);
    end
    wr(3'd2, 8'h02);
    @(negedge clk);
    rd(3'd0, d);
    checks++;
    if (d !== 8'h02) begin
      errors++;
      $display("FAIL level_repend got %h exp 02", d);
    end
    checks++;
    if (irqb !== 1'b0) begin
      errors++;
      $display("FAIL level_irqb got %b exp 0", irqb);
    end
    irq_src = 8'h00;
    repeat (3) @(negedge clk);
    wr(3'd2, 8'h02);
    rd(3'd0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL level_clear got %h exp 00", d);
    end
    @(negedge clk);
    checks++;
    if (irqb !== 1'b1) begin
      errors++;
      $display("FAIL level_idle_irqb got %b exp 1", irqb);
    end
    wr(3'd4, 8'hFF);
  endtask

  task automatic test_priority();
    logic [7:0] d;
    wr(3'd1, 8'hFF);
    pulse(8'h24);
    repeat (3) @(negedge clk);
    rd(3'd0, d);
    checks++;
    if (d !== 8'h24) begin
      errors++;
      $display("FAIL prio_status got %h exp 24", d);
    end
    rd(3'd3, d);
    checks++;
    if (d !== 8'h82) begin
      errors++;
      $display("FAIL prio_active2 got %h exp 82", d);
    end
    wr(3'd2, 8'h04);
    rd(3'd3, d);
    checks++;
    if (d !== 8'h85) begin
      errors++;
      $display("FAIL prio_active5 got %h exp 85", d);
    end
    wr(3'd2, 8'h20);
    rd(3'd3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL prio_none got %h exp 00", d);
    end
    @(negedge clk);
    checks++;
    if (irqb !== 1'b1) begin
      errors++;
      $display("FAIL prio_irqb got %b exp 1", irqb);
    end
  endtask

  task automatic test_mask();
    logic [7:0] d;
    wr(3'd1, 8'h00);
    pulse(8'h08);
    repeat (4) @(negedge clk);
    rd(3'd0, d);
    checks++;
    if (d !== 8'h08) begin
      errors++;
      $display("FAIL mask_status got %h exp 08", d);
    end
    checks++;
    if (irqb !== 1'b1) begin
      errors++;
      $display("FAIL mask_irqb got %b exp 1", irqb);
    end
    wr(3'd1, 8'h08);
    checks++;
    if (irqb !== 1'b1) begin
      errors++;
      $display("FAIL unmask_early got %b exp 1", irqb);
    end
    @(negedge clk);
    checks++;
    if (irqb !== 1'b0) begin
      errors++;
      $display("FAIL unmask_irqb got %b exp 0", irqb);
    end
    wr(3'd2, 8'h08);
    wr(3'd1, 8'h00);
  endtask

  task automatic test_set_wins();
    logic [7:0] d;
    wr(3'd5, 8'h10);
    @(negedge clk);
    irq_src = 8'h10;
    @(negedge clk);
    irq_src = 8'h00;
    @(negedge clk);
    bus.cs      = 1'b1;
    bus.rw      = 1'b0;
    bus.addr    = 3'd2;
    bus.data_in = 8'h10;
    @(negedge clk);
    bus.cs = 1'b0;
    bus.rw = 1'b1;
    rd(3'd0, d);
    checks++;
    if (d !== 8'h10) begin
      errors++;
      $display("FAIL setwins_status got %h exp 10", d);
    end
    wr(3'd2, 8'h10);
    rd(3'd0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL setwins_clear got %h exp 00", d);
    end
    wr(3'd1, 8'h80);
    wr(3'd5, 8'h80);
    rd(3'd5, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL swset_read got %h exp 00", d);
    end
    @(negedge clk);
    checks++;
    if (irqb !== 1'b0) begin
      errors++;
      $display("FAIL swset_irqb got %b exp 0", irqb);
    end
    rd(3'd3, d);
    checks++;
    if (d !== 8'h87) begin
      errors++;
      $display("FAIL swset_active got %h exp 87", d);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (irqb !== 1'b1) begin
      errors++;
      $display("FAIL arst_irqb got %b exp 1", irqb);
    end
    rd(3'd0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL arst_status got %h exp 00", d);
    end
    rd(3'd1, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL arst_mask got %h exp 00", d);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    irq_src     = 8'h00;
    bus.cs      = 1'b0;
    bus.rw      = 1'b1;
    bus.addr    = 3'd0;
    bus.data_in = 8'h00;
    test_reset();
    test_edge_latency();
    test_level();
    test_priority();
    test_mask();
    test_set_wins();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
